// File: rtl/alu_cmd_sequencer.sv
// Stored command list initiator for the ALU/accumulator datapath.
// Issues up to DEPTH {op, a} commands over valid/ready and samples the result.
module alu_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_op,
  input  logic [3:0]    wr_a,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic [2:0]    op_sel,
  output logic [3:0]    op_a,
  output logic          op_valid,
  input  logic          op_ready,
  input  logic [7:0]    res_in,
  output logic          busy,
  output logic          done,
  output logic [7:0]    res_last,
  output logic [AW:0]   cmd_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

  state_t        state;
  logic [2:0]    slot_op [DEPTH];
  logic [3:0]    slot_a  [DEPTH];
  logic [AW:0]   n;
  logic [AW-1:0] idx;

  logic [AW:0]   len_c;
  logic [AW-1:0] nidx;
  logic [2:0]    fwd_op;
  logic [3:0]    fwd_a;
  logic [AW:0]   cnt_nx;

  // Slot 0 is forwarded so a write in the start cycle is seen by the run.
  always_comb begin
    len_c  = (len > DMAX) ? DMAX : len;
    nidx   = idx + AW'(1);
    cnt_nx = cmd_count + (AW+1)'(1);
    fwd_op = slot_op[0];
    fwd_a  = slot_a[0];
    if (wr_en && (wr_addr == '0)) begin
      fwd_op = wr_op;
      fwd_a  = wr_a;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n         <= '0;
      idx       <= '0;
      op_sel    <= '0;
      op_a      <= '0;
      op_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_last  <= '0;
      cmd_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_op[i] <= '0;
        slot_a[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_en) begin
            slot_op[wr_addr] <= wr_op;
            slot_a[wr_addr]  <= wr_a;
          end
          if (start) begin
            n         <= len_c;
            idx       <= '0;
            cmd_count <= '0;
            if (len_c == '0) begin
              state <= DONE;
            end else begin
              state    <= ISSUE;
              busy     <= 1'b1;
              op_valid <= 1'b1;
              op_sel   <= fwd_op;
              op_a     <= fwd_a;
            end
          end
        end
        ISSUE: begin
          if (op_ready) begin
            state    <= SETTLE;
            op_valid <= 1'b0;
            op_sel   <= '0;
            op_a     <= '0;
          end
        end
        SETTLE: begin
          res_last  <= res_in;
          cmd_count <= cnt_nx;
          idx       <= nidx;
          if (cnt_nx == n) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            state    <= ISSUE;
            op_valid <= 1'b1;
            op_sel   <= slot_op[nidx];
            op_a     <= slot_a[nidx];
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
